credit_link_tx: RTL and testbench
=================================

// Module: credit_link_tx
// PURPOSE
//  Transmit side of a credit-based NoC link. Sits downstream of a router output port and upstream of the link wires.
//  Accepts flits over valid/ready, registers them onto the link, and tracks downstream buffer space in a credit counter.
//  Credits are decremented per flit sent and incremented per credit returned; low/empty flags feed the router's arbiter.
// PARAMETERS
//  DATA_WIDTH        8   flit width in bits
//  MAX_CREDITS       8   downstream buffer depth; credit counter reset value
//  CREDIT_WIDTH      4   counter width; must satisfy 2**CREDIT_WIDTH > MAX_CREDITS
//  LOW_CREDIT_LEVEL  2   low_credit_o asserted when credits <= this value
// PORTS
//  clk_i           in   1             clock, all logic on rising edge
//  rst_i           in   1             asynchronous reset, active-high
//  data_i          in   DATA_WIDTH    flit from router
//  valid_i         in   1             flit on data_i is valid
//  ready_o         out  1             block can accept a flit this cycle
//  data_o          out  DATA_WIDTH    flit on link (registered)
//  valid_o         out  1             data_o valid this cycle (registered)
//  credit_i        in   1             one-cycle pulse = one downstream slot freed
//  credits_o       out  CREDIT_WIDTH  current credit count
//  low_credit_o    out  1             credits_o <= LOW_CREDIT_LEVEL
//  no_credit_o     out  1             credits_o == 0
//  credit_err_o    out  1             sticky: credit returned while counter at MAX_CREDITS
// BEHAVIOUR
//  Reset (async, rst_i=1): credits=MAX_CREDITS, valid_o=0, data_o=0, credit_err_o=0; held while rst_i high.
//  Reset mid-operation: in-flight flit in output register is dropped, counter returns to MAX_CREDITS.
//  ready_o = (credits != 0); depends only on registered state, never on valid_i (no comb. loop).
//  Transfer: xfer = valid_i & ready_o. On xfer, next cycle valid_o=1, data_o=data_i (latency 1).
//  No xfer: next cycle valid_o=0, data_o holds last value.
//  Credit update per cycle (credit_i = ret):
//   - xfer & !ret  -> credits-1
//   - !xfer & ret  -> credits+1, except at MAX_CREDITS: hold, set credit_err_o
//   - xfer & ret   -> hold (net zero); legal even at MAX_CREDITS, no error
//   - neither      -> hold
//  Underflow impossible: xfer requires credits != 0. At credits==1, xfer drives 0 and ready_o drops next cycle.
//  Zero-credit recovery: credits==0 and credit_i -> credits=1, ready_o=1 the following cycle.
//  credit_err_o cleared only by reset.
//  low_credit_o, no_credit_o: combinational decodes of the credit register, valid same cycle as credits_o.
//  Arithmetic is unsigned CREDIT_WIDTH; no wrap-around ever occurs (saturate at MAX_CREDITS, floor at 0).
//  Elaboration check: MAX_CREDITS >= 1, MAX_CREDITS < 2**CREDIT_WIDTH, LOW_CREDIT_LEVEL < MAX_CREDITS; else $error.
// STRUCTURE
//  Shared include noc_params.vh: default DATA_WIDTH, MAX_CREDITS, CREDIT_WIDTH, LOW_CREDIT_LEVEL localparams,
//   so router, link rx buffer and this block agree on buffer depth.
//  Sub-module credit_counter: saturating up/down/hold counter with inc_i, dec_i, cnt_o, sat_err_o, low/zero decodes.
//  Top level: handshake logic, output flit register, credit_counter instance.
// TESTING
//  1 Reset: assert rst_i mid-stream with credits=3 -> same cycle valid_o=0, credits_o=8, credit_err_o=0.
//  2 Drain: valid_i=1 for 10 cycles, no credit_i -> exactly 8 flits on valid_o, ready_o=0 from cycle 8, credits_o=0,
//    no_credit_o=1, low_credit_o=1 once credits_o<=2.
//  3 Recovery: from credits=0, pulse credit_i once -> credits_o=1, ready_o=1 next cycle, one flit sent, back to 0.
//  4 Simultaneous: credits=5, valid_i=1 and credit_i=1 for 4 cycles -> credits_o stays 5, 4 flits out in order.
//  5 Overflow: credits=8, valid_i=0, credit_i=1 -> credits_o stays 8, credit_err_o=1 and stays 1 until rst_i.
//  6 Latency/data: send 0xA5 then 0x3C back-to-back -> data_o=0xA5 one cycle after accept, 0x3C the next; valid_o=1 both.

Source files
------------

// File: rtl/credit_link_tx_pkg.sv
// Shared NoC link parameters and credit-counter operation encoding, so the router,
// link rx buffer and credit_link_tx agree on flit width and downstream buffer depth.
package credit_link_tx_pkg;

  localparam int unsigned NOC_DATA_WIDTH       = 8;
  localparam int unsigned NOC_MAX_CREDITS      = 8;
  localparam int unsigned NOC_CREDIT_WIDTH     = 4;
  localparam int unsigned NOC_LOW_CREDIT_LEVEL = 2;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_DEC  = 2'd1,
    CNT_INC  = 2'd2
  } cnt_op_e;

  // A simultaneous increment and decrement cancel out, so they map to hold.
  function automatic cnt_op_e cnt_op(input logic inc, input logic dec);
    if (inc && !dec) return CNT_INC;
    if (dec && !inc) return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/credit_link_tx_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag and low/zero decodes.
module credit_counter
  import credit_link_tx_pkg::*;
#(
  parameter int unsigned MAX_CREDITS      = NOC_MAX_CREDITS,
  parameter int unsigned CREDIT_WIDTH     = NOC_CREDIT_WIDTH,
  parameter int unsigned LOW_CREDIT_LEVEL = NOC_LOW_CREDIT_LEVEL
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    inc_i,
  input  logic                    dec_i,
  output logic [CREDIT_WIDTH-1:0] cnt_o,
  output logic                    sat_err_o,
  output logic                    low_o,
  output logic                    zero_o
);

  localparam logic [CREDIT_WIDTH-1:0] MAX_C = CREDIT_WIDTH'(MAX_CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] LOW_C = CREDIT_WIDTH'(LOW_CREDIT_LEVEL);
  localparam logic [CREDIT_WIDTH-1:0] ONE   = CREDIT_WIDTH'(1);

  cnt_op_e op;

  always_comb begin
    op = cnt_op(inc_i, dec_i);
  end

  // Counter floors at zero and saturates at MAX_C; an increment at MAX_C flags an error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o     <= MAX_C;
      sat_err_o <= 1'b0;
    end else begin
      unique case (op)
        CNT_DEC: begin
          if (cnt_o != '0) cnt_o <= cnt_o - ONE;
        end
        CNT_INC: begin
          if (cnt_o == MAX_C) sat_err_o <= 1'b1;
          else                cnt_o     <= cnt_o + ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    low_o  = (cnt_o <= LOW_C);
    zero_o = (cnt_o == '0);
  end

endmodule

// File: rtl/credit_link_tx.sv
// Transmit side of a credit-based NoC link: valid/ready flit intake, registered
// link output, and downstream credit tracking with low/empty flags for arbitration.
module credit_link_tx
  import credit_link_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = NOC_DATA_WIDTH,
  parameter int unsigned MAX_CREDITS      = NOC_MAX_CREDITS,
  parameter int unsigned CREDIT_WIDTH     = NOC_CREDIT_WIDTH,
  parameter int unsigned LOW_CREDIT_LEVEL = NOC_LOW_CREDIT_LEVEL
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    credit_i,
  output logic [CREDIT_WIDTH-1:0] credits_o,
  output logic                    low_credit_o,
  output logic                    no_credit_o,
  output logic                    credit_err_o
);

  if (MAX_CREDITS < 1 || MAX_CREDITS >= (2 ** CREDIT_WIDTH) ||
      LOW_CREDIT_LEVEL >= MAX_CREDITS) begin : g_param_check
    $error("credit_link_tx: illegal MAX_CREDITS/CREDIT_WIDTH/LOW_CREDIT_LEVEL combination");
  end

  logic xfer;

  // ready_o comes only from the credit register, so there is no path from valid_i.
  always_comb begin
    ready_o = ~no_credit_o;
    xfer    = valid_i & ready_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      valid_o <= xfer;
      if (xfer) data_o <= data_i;
    end
  end

  credit_counter #(
    .MAX_CREDITS      (MAX_CREDITS),
    .CREDIT_WIDTH     (CREDIT_WIDTH),
    .LOW_CREDIT_LEVEL (LOW_CREDIT_LEVEL)
  ) u_credit_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (credit_i),
    .dec_i     (xfer),
    .cnt_o     (credits_o),
    .sat_err_o (credit_err_o),
    .low_o     (low_credit_o),
    .zero_o    (no_credit_o)
  );

endmodule

// File: tb/tb_credit_link_tx.sv
// Directed bench for credit_link_tx: reset, drain, zero-credit recovery,
// simultaneous send/return, overflow and flit latency, with hand-computed expectations.
module tb_credit_link_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       credit_i;
  logic [3:0] credits_o;
  logic       low_credit_o;
  logic       no_credit_o;
  logic       credit_err_o;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned flits       = 0;
  int unsigned exp_cr;

  always #5 clk = ~clk;

  credit_link_tx #(
    .DATA_WIDTH       (8),
    .MAX_CREDITS      (8),
    .CREDIT_WIDTH     (4),
    .LOW_CREDIT_LEVEL (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .credit_i     (credit_i),
    .credits_o    (credits_o),
    .low_credit_o (low_credit_o),
    .no_credit_o  (no_credit_o),
    .credit_err_o (credit_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; credit_i = 1'b0; data_i = 8'h00;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_credits", credits_o, 8);
    chk("rst_valid",   valid_o, 0);
    chk("rst_data",    data_o, 8'h00);
    chk("rst_err",     credit_err_o, 0);
    chk("rst_ready",   ready_o, 1);
    chk("rst_low",     low_credit_o, 0);
    chk("rst_none",    no_credit_o, 0);

    // Latency/data: A5 then 3C back-to-back
    valid_i = 1'b1; data_i = 8'hA5;
    step();
    chk("lat_valid0", valid_o, 1);
    chk("lat_data0",  data_o, 8'hA5);
    chk("lat_cr0",    credits_o, 7);
    data_i = 8'h3C;
    step();
    chk("lat_valid1", valid_o, 1);
    chk("lat_data1",  data_o, 8'h3C);
    chk("lat_cr1",    credits_o, 6);
    valid_i = 1'b0; data_i = 8'hFF;
    step();
    chk("idle_valid", valid_o, 0);
    chk("idle_hold",  data_o, 8'h3C);
    chk("idle_cr",    credits_o, 6);

    // Overflow: refill to 8, then one extra return
    credit_i = 1'b1;
    step();
    chk("ret_cr7", credits_o, 7);
    step();
    chk("ret_cr8", credits_o, 8);
    chk("ret_err", credit_err_o, 0);
    step();
    chk("ovf_cr",  credits_o, 8);
    chk("ovf_err", credit_err_o, 1);
    credit_i = 1'b0;
    step();
    chk("ovf_sticky", credit_err_o, 1);

    // Drain: 10 cycles of valid_i from 8 credits
    valid_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      data_i = 8'h10 + 8'(k);
      step();
      exp_cr = (k >= 8) ? 0 : 8 - k;
      if (valid_o === 1'b1) flits++;
      chk("drain_cr",    credits_o, exp_cr);
      chk("drain_valid", valid_o, (k <= 8) ? 1 : 0);
      if (k <= 8) chk("drain_data", data_o, 8'h10 + k);
      chk("drain_ready", ready_o, (k < 8) ? 1 : 0);
      chk("drain_low",   low_credit_o, (exp_cr <= 2) ? 1 : 0);
      chk("drain_none",  no_credit_o, (exp_cr == 0) ? 1 : 0);
    end
    chk("drain_flits", flits, 8);
    chk("drain_err",   credit_err_o, 1);

    // Recovery from zero credits
    valid_i = 1'b0; credit_i = 1'b1;
    step();
    chk("rec_cr",    credits_o, 1);
    chk("rec_ready", ready_o, 1);
    chk("rec_none",  no_credit_o, 0);
    chk("rec_low",   low_credit_o, 1);
    credit_i = 1'b0; valid_i = 1'b1; data_i = 8'h77;
    step();
    chk("rec_valid", valid_o, 1);
    chk("rec_data",  data_o, 8'h77);
    chk("rec_cr0",   credits_o, 0);
    chk("rec_ready0", ready_o, 0);
    data_i = 8'h88;
    step();
    chk("rec_blocked_valid", valid_o, 0);
    chk("rec_blocked_data",  data_o, 8'h77);
    chk("rec_blocked_cr",    credits_o, 0);
    valid_i = 1'b0;

    // Return 5 credits, then simultaneous send/return
    credit_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    credit_i = 1'b0;
    chk("refill_cr",  credits_o, 5);
    chk("refill_low", low_credit_o, 0);
    valid_i = 1'b1; credit_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'h40 + 8'(i);
      step();
      chk("sim_cr",    credits_o, 5);
      chk("sim_valid", valid_o, 1);
      chk("sim_data",  data_o, 8'h40 + i);
    end
    valid_i = 1'b0; credit_i = 1'b0;
    step();
    chk("sim_end_valid", valid_o, 0);
    chk("sim_end_cr",    credits_o, 5);

    // Reset mid-stream with credits=3 and a flit in the output register
    valid_i = 1'b1; data_i = 8'h51;
    step();
    data_i = 8'h52;
    step();
    chk("pre_rst_cr",    credits_o, 3);
    chk("pre_rst_valid", valid_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_cr",    credits_o, 8);
    chk("async_rst_err",   credit_err_o, 0);
    chk("async_rst_data",  data_o, 8'h00);
    step();
    chk("held_rst_cr",    credits_o, 8);
    chk("held_rst_valid", valid_o, 0);
    rst = 1'b0; valid_i = 1'b0;
    step();

    // Send and return together at MAX_CREDITS: legal, no error
    valid_i = 1'b1; credit_i = 1'b1; data_i = 8'h99;
    step();
    chk("max_both_cr",    credits_o, 8);
    chk("max_both_err",   credit_err_o, 0);
    chk("max_both_valid", valid_o, 1);
    chk("max_both_data",  data_o, 8'h99);
    valid_i = 1'b0; credit_i = 1'b0;
    step();
    chk("final_valid", valid_o, 0);
    chk("final_err",   credit_err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
